// File: rtl/tag_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tag_ctrl_pkg
//  Description : Shared definitions for the L1 tag lookup controller:
//                MSI state encoding, FSM state encoding and state helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package tag_ctrl_pkg;

  // MSI coherence state encoding held in the top two bits of a tag word
  localparam int          STATE_W = 2;
  localparam logic [1:0]  MSI_I   = 2'b00;
  localparam logic [1:0]  MSI_S   = 2'b01;
  localparam logic [1:0]  MSI_M   = 2'b10;

  // Controller sequencing: one lookup occupies exactly three cycles
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_COMMIT = 2'd2
  } fsm_e;

  // The unused code 2'b11 is folded onto Invalid, both on read and before write
  function automatic logic [1:0] msi_norm(input logic [1:0] s);
    return (s == 2'b11) ? MSI_I : s;
  endfunction

  function automatic logic msi_valid(input logic [1:0] s);
    return (msi_norm(s) != MSI_I);
  endfunction

endpackage : tag_ctrl_pkg
`default_nettype wire

// File: rtl/tag_way_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tag_way_cmp
//  Description : Per-way tag comparator. Splits a tag RAM word into MSI state
//                and tag, and flags a hit when the way is valid and matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_way_cmp
  import tag_ctrl_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH-1:0] i_dout,
  input  logic [DWIDTH-3:0] i_req_tag,
  output logic              o_hit,
  output logic [1:0]        o_state
);

  // Decode stored state and compare the tag field against the request
  always_comb begin
    o_state = msi_norm(i_dout[DWIDTH-1:DWIDTH-2]);
    o_hit   = msi_valid(o_state) && (i_dout[DWIDTH-3:0] == i_req_tag);
  end

endmodule : tag_way_cmp
`default_nettype wire

// File: rtl/tag_lookup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tag_lookup_ctrl
//  Description : Arbitrates CPU and snoop requests onto the two tag RAM ways
//                of a 2-way MSI L1, compares tags, reports hit/way/state and
//                optionally writes back a new state (victim fill on CPU miss).
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_lookup_ctrl
  import tag_ctrl_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic [DWIDTH+AWIDTH-3:0] cpu_addr,
  input  logic                     cpu_wr,
  input  logic [1:0]               cpu_new_state,
  output logic                     cpu_ack,
  input  logic                     snp_req,
  input  logic [DWIDTH+AWIDTH-3:0] snp_addr,
  input  logic                     snp_wr,
  input  logic [1:0]               snp_new_state,
  output logic                     snp_ack,
  output logic                     rsp_valid,
  output logic                     rsp_src,
  output logic                     rsp_hit,
  output logic                     rsp_way,
  output logic [1:0]               rsp_state,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we0,
  output logic                     ram_we1,
  input  logic [DWIDTH-1:0]        ram_dout0,
  input  logic [DWIDTH-1:0]        ram_dout1,
  output logic                     busy
);

  localparam int TAG_W = DWIDTH - 2;
  localparam int DEPTH = 1 << AWIDTH;

  // Latched request and registered lookup result
  fsm_e              state_q,  state_d;
  logic [AWIDTH-1:0] idx_q,    idx_d;
  logic [TAG_W-1:0]  tag_q,    tag_d;
  logic              wr_q,     wr_d;
  logic [1:0]        nst_q,    nst_d;
  logic              src_q,    src_d;
  logic              hit_q,    hit_d;
  logic              way_q,    way_d;
  logic [1:0]        rstate_q, rstate_d;
  logic [DEPTH-1:0]  lru_q,    lru_d;

  // Combinational outputs before reset gating
  logic              cpu_ack_c, snp_ack_c, rsp_valid_c, we0_c, we1_c;
  logic [AWIDTH-1:0] ram_addr_c;
  logic [DWIDTH-1:0] ram_din_c;

  // Per-way comparison results
  logic [DWIDTH-1:0] way_dout  [2];
  logic [1:0]        way_hit;
  logic [1:0]        way_state [2];
  logic              victim;
  logic [DWIDTH+AWIDTH-3:0] req_addr;

  assign way_dout[0] = ram_dout0;
  assign way_dout[1] = ram_dout1;

  for (genvar w = 0; w < 2; w++) begin : g_way
    tag_way_cmp #(
      .DWIDTH    (DWIDTH)
    ) u_cmp (
      .i_dout    (way_dout[w]),
      .i_req_tag (tag_q),
      .o_hit     (way_hit[w]),
      .o_state   (way_state[w])
    );
  end

  // Victim: first invalid way, otherwise the least recently used one
  always_comb begin
    if (way_state[0] == MSI_I)      victim = 1'b0;
    else if (way_state[1] == MSI_I) victim = 1'b1;
    else                            victim = lru_q[idx_q];
  end

  // Snoop has strict priority; the mux only matters on a grant
  assign req_addr = snp_req ? snp_addr : cpu_addr;

  // Next-state, datapath and RAM control for the three-cycle transaction
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    wr_d        = wr_q;
    nst_d       = nst_q;
    src_d       = src_q;
    hit_d       = hit_q;
    way_d       = way_q;
    rstate_d    = rstate_q;
    lru_d       = lru_q;
    cpu_ack_c   = 1'b0;
    snp_ack_c   = 1'b0;
    rsp_valid_c = 1'b0;
    we0_c       = 1'b0;
    we1_c       = 1'b0;
    ram_addr_c  = '0;
    ram_din_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (snp_req || cpu_req) begin
          snp_ack_c  = snp_req;
          cpu_ack_c  = ~snp_req;
          src_d      = snp_req;
          idx_d      = req_addr[AWIDTH-1:0];
          tag_d      = req_addr[DWIDTH+AWIDTH-3:AWIDTH];
          wr_d       = snp_req ? snp_wr : cpu_wr;
          nst_d      = msi_norm(snp_req ? snp_new_state : cpu_new_state);
          ram_addr_c = req_addr[AWIDTH-1:0];
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        ram_addr_c = idx_q;
        hit_d      = |way_hit;
        way_d      = way_hit[0] ? 1'b0 : (way_hit[1] ? 1'b1 : victim);
        rstate_d   = way_hit[0] ? way_state[0] :
                     (way_hit[1] ? way_state[1] : MSI_I);
        state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        rsp_valid_c = 1'b1;
        ram_addr_c  = idx_q;
        ram_din_c   = {nst_q, tag_q};
        // Snoops update a hit line but never allocate on a miss
        if (wr_q && (hit_q || !src_q)) begin
          we0_c = ~way_q;
          we1_c = way_q;
        end
        // Only CPU hits and CPU fills age the set
        if (!src_q && (hit_q || wr_q)) begin
          lru_d[idx_q] = ~way_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset abandons any transaction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      wr_q     <= 1'b0;
      nst_q    <= MSI_I;
      src_q    <= 1'b0;
      hit_q    <= 1'b0;
      way_q    <= 1'b0;
      rstate_q <= MSI_I;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      wr_q     <= wr_d;
      nst_q    <= nst_d;
      src_q    <= src_d;
      hit_q    <= hit_d;
      way_q    <= way_d;
      rstate_q <= rstate_d;
      lru_q    <= lru_d;
    end
  end

  // Reset forces every output low in the very cycle it is asserted,
  // so an interrupted COMMIT never reaches the RAMs
  assign cpu_ack   = cpu_ack_c   & ~reset;
  assign snp_ack   = snp_ack_c   & ~reset;
  assign rsp_valid = rsp_valid_c & ~reset;
  assign rsp_src   = rsp_valid & src_q;
  assign rsp_hit   = rsp_valid & hit_q;
  assign rsp_way   = rsp_valid & way_q;
  assign rsp_state = rsp_valid ? rstate_q : MSI_I;
  assign ram_we0   = we0_c & ~reset;
  assign ram_we1   = we1_c & ~reset;
  assign ram_addr  = reset ? '0 : ram_addr_c;
  assign ram_din   = reset ? '0 : ram_din_c;
  assign busy      = ~reset & (state_q != ST_IDLE);

endmodule : tag_lookup_ctrl
`default_nettype wire

// File: tb/tb_tag_lookup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tag_lookup_ctrl
//  Description : Scoreboard bench for tag_lookup_ctrl with two 1-cycle
//                sync-read tag RAM models and a backdoor preload port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_lookup_ctrl;

  localparam logic [1:0] I_ST = 2'b00;
  localparam logic [1:0] S_ST = 2'b01;
  localparam logic [1:0] M_ST = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, cpu_ack;
  logic [16:0] cpu_addr;
  logic [1:0]  cpu_new_state;
  logic        snp_req, snp_wr, snp_ack;
  logic [16:0] snp_addr;
  logic [1:0]  snp_new_state;
  logic        rsp_valid, rsp_src, rsp_hit, rsp_way;
  logic [1:0]  rsp_state;
  logic [2:0]  ram_addr;
  logic [15:0] ram_din, ram_dout0, ram_dout1;
  logic        ram_we0, ram_we1, busy;

  logic [15:0] mem0 [8];
  logic [15:0] mem1 [8];
  logic        bd_we;
  logic [2:0]  bd_a;
  logic [15:0] bd_d0, bd_d1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    bit          src;
    bit          hit;
    bit          way;
    logic [1:0]  st;
    bit          we0;
    bit          we1;
    logic [15:0] din;
    int          acyc;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;

  tag_lookup_ctrl #(.AWIDTH(3), .DWIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_wr        (cpu_wr),
    .cpu_new_state (cpu_new_state),
    .cpu_ack       (cpu_ack),
    .snp_req       (snp_req),
    .snp_addr      (snp_addr),
    .snp_wr        (snp_wr),
    .snp_new_state (snp_new_state),
    .snp_ack       (snp_ack),
    .rsp_valid     (rsp_valid),
    .rsp_src       (rsp_src),
    .rsp_hit       (rsp_hit),
    .rsp_way       (rsp_way),
    .rsp_state     (rsp_state),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we0       (ram_we0),
    .ram_we1       (ram_we1),
    .ram_dout0     (ram_dout0),
    .ram_dout1     (ram_dout1),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Tag RAM models: write-before-nothing, read returns the old word
  always @(posedge clock) begin
    if (bd_we) begin
      mem0[bd_a] <= bd_d0;
      mem1[bd_a] <= bd_d1;
    end else begin
      if (ram_we0) mem0[ram_addr] <= ram_din;
      if (ram_we1) mem1[ram_addr] <= ram_din;
    end
    ram_dout0 <= mem0[ram_addr];
    ram_dout1 <= mem1[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [16:0] mk(input logic [13:0] t, input logic [2:0] i);
    return {t, i};
  endfunction

  // Response monitor: pops the scoreboard on every result pulse
  always @(negedge clock) begin
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_src",     {31'd0, rsp_src}, {31'd0, mon_e.src});
        chk("rsp_hit",     {31'd0, rsp_hit}, {31'd0, mon_e.hit});
        chk("rsp_way",     {31'd0, rsp_way}, {31'd0, mon_e.way});
        chk("rsp_state",   {30'd0, rsp_state}, {30'd0, mon_e.st});
        chk("rsp_latency", cyc - mon_e.acyc, 32'd2);
        chk("ram_we0",     {31'd0, ram_we0}, {31'd0, mon_e.we0});
        chk("ram_we1",     {31'd0, ram_we1}, {31'd0, mon_e.we1});
        if (mon_e.we0 || mon_e.we1) chk("ram_din", {16'd0, ram_din}, {16'd0, mon_e.din});
      end
    end else begin
      chk("stray_we", {30'd0, ram_we1, ram_we0}, 32'd0);
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clock);
    bd_a = a; bd_d0 = d0; bd_d1 = d1; bd_we = 1'b1;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {22'd0, cpu_ack, snp_ack, rsp_valid, rsp_src, rsp_hit, rsp_way,
                        rsp_state, ram_we0, ram_we1, busy}, 32'd0);
    chk({tag, "_addr"}, {29'd0, ram_addr}, 32'd0);
    chk({tag, "_din"},  {16'd0, ram_din},  32'd0);
  endtask

  // Leaves the caller at negedge+2 of an idle cycle
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock); #2;
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request and push its expected result
  task automatic issue(input bit src, input logic [16:0] addr, input bit wr,
                       input logic [1:0] ns, input bit ehit, input bit eway,
                       input logic [1:0] est, input bit ewe);
    bit   got;
    exp_t e;
    @(negedge clock);
    if (src) begin
      snp_req = 1'b1; snp_addr = addr; snp_wr = wr; snp_new_state = ns;
    end else begin
      cpu_req = 1'b1; cpu_addr = addr; cpu_wr = wr; cpu_new_state = ns;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #2;
      if (src ? snp_ack : cpu_ack) got = 1'b1;
      else @(negedge clock);
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("other_ack_low", {31'd0, (src ? cpu_ack : snp_ack)}, 32'd0);
      e.src = src; e.hit = ehit; e.way = eway; e.st = est;
      e.we0 = ewe && !eway; e.we1 = ewe && eway;
      e.din = {ns, addr[16:3]}; e.acyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clock); #1;
    cpu_req = 1'b0; snp_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit   got;
    int   t0;
    exp_t e;
    reset = 1'b1; bd_we = 1'b0; bd_a = '0; bd_d0 = '0; bd_d1 = '0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_new_state = I_ST;
    snp_req = 1'b0; snp_addr = '0; snp_wr = 1'b0; snp_new_state = I_ST;
    for (int i = 0; i < 8; i++) preload(i[2:0], 16'h0000, 16'h0000);
    @(negedge clock); #2;
    check_zero("reset");
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); #2;
    check_zero("idle");

    // Plain CPU read hit in way 0
    preload(3'd2, 16'h4123, 16'h0000);
    issue(0, mk(14'h0123, 3'd2), 0, I_ST, 1, 0, S_ST, 0);

    // Set 5: make lru[5]=1 via a way-0 hit, then fill goes to way 1 and flips LRU
    preload(3'd5, 16'h4111, 16'h8222);
    issue(0, mk(14'h0111, 3'd5), 0, I_ST, 1, 0, S_ST, 0);
    issue(0, mk(14'h0ABC, 3'd5), 1, M_ST, 0, 1, I_ST, 1);
    issue(0, mk(14'h0DEF, 3'd5), 1, S_ST, 0, 0, I_ST, 1);

    // Simultaneous requests: snoop first, CPU granted three cycles later
    wait_idle();
    cpu_req = 1'b1; cpu_addr = mk(14'h0DEF, 3'd5); cpu_wr = 1'b0; cpu_new_state = I_ST;
    snp_req = 1'b1; snp_addr = mk(14'h0ABC, 3'd5); snp_wr = 1'b0; snp_new_state = I_ST;
    #2;
    chk("dual_snp_ack", {31'd0, snp_ack}, 32'd1);
    chk("dual_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    t0 = cyc;
    e.src = 1; e.hit = 1; e.way = 1; e.st = M_ST; e.we0 = 0; e.we1 = 0; e.din = '0; e.acyc = cyc;
    sbq.push_back(e);
    @(posedge clock); #1 snp_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock); #2;
      if (cpu_ack) got = 1'b1;
    end
    chk("dual_cpu_ack_seen", {31'd0, got}, 32'd1);
    chk("dual_cpu_gap", cyc - t0, 32'd3);
    e.src = 0; e.hit = 1; e.way = 0; e.st = S_ST; e.acyc = cyc;
    sbq.push_back(e);
    @(posedge clock); #1 cpu_req = 1'b0;

    // Snoop invalidates a Modified line in way 1
    issue(1, mk(14'h0ABC, 3'd5), 1, I_ST, 1, 1, M_ST, 1);

    // Snoop hit must not age the set: later CPU fill still evicts way 0
    preload(3'd6, 16'h4AAA, 16'h4BBB);
    issue(1, mk(14'h0AAA, 3'd6), 1, S_ST, 1, 0, S_ST, 1);
    issue(0, mk(14'h0CCC, 3'd6), 1, M_ST, 0, 0, I_ST, 1);
    // Snoop miss with wr never allocates; a CPU probe confirms set 6 untouched
    issue(1, mk(14'h0DDD, 3'd6), 1, S_ST, 0, 1, I_ST, 0);
    issue(0, mk(14'h0DDD, 3'd6), 0, I_ST, 0, 1, I_ST, 0);

    // State code 2'b11 reads as Invalid
    preload(3'd7, 16'hC0EE, 16'h4001);
    issue(0, mk(14'h00EE, 3'd7), 0, I_ST, 0, 0, I_ST, 0);

    // Read-after-write on back-to-back transactions
    issue(0, mk(14'h0333, 3'd3), 1, S_ST, 0, 0, I_ST, 1);
    issue(0, mk(14'h0333, 3'd3), 0, I_ST, 1, 0, S_ST, 0);

    // Reset during COMMIT of a CPU fill
    wait_idle();
    cpu_req = 1'b1; cpu_addr = mk(14'h0555, 3'd4); cpu_wr = 1'b1; cpu_new_state = M_ST;
    #2;
    chk("rst_mid_ack", {31'd0, cpu_ack}, 32'd1);
    @(posedge clock); #1 cpu_req = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock); #2;
    check_zero("rst_commit");
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); #2;
    check_zero("post_rst");
    // Interrupted fill left set 4 empty; cleared LRU makes set 6 evict way 0
    issue(0, mk(14'h0555, 3'd4), 0, I_ST, 0, 0, I_ST, 0);
    issue(0, mk(14'h0EEE, 3'd6), 0, I_ST, 0, 0, I_ST, 0);

    repeat (5) @(negedge clock);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tag_lookup_ctrl
`default_nettype wire
